freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter frec_in, default 100_000_000, clk_in frequency in Hz (documentation only; not used in datapath).
REQ-002 SHALL have parameter GATE_CYCLES, default 100_000_000, gate window length in clk_in cycles (1 s at default, so the count reads directly in Hz).
REQ-003 SHALL have localparam COUNT_W = $clog2(GATE_CYCLES/2 + 1), the edge-count width.
REQ-004 clk_in  input  1  sole clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; state clears while low.
REQ-006 sig_in  input  1  signal under measurement, asynchronous to clk_in.
REQ-007 start  input  1  single-cycle request to begin one measurement.
REQ-008 busy  output  1  high while a measurement is in progress.
REQ-009 freq_count  output  COUNT_W  rising-edge count of the last completed window.
REQ-010 valid  output  1  one-cycle pulse when freq_count updates.
REQ-011 overflow  output  1  the last window's count saturated.

Function
REQ-012 sig_in SHALL pass through a 2-FF synchronizer, then a rising-edge detector producing a one-cycle edge pulse; sig_in-to-pulse latency 3 clk_in cycles.
REQ-013 FSM states: IDLE, MEASURE, DONE.
REQ-014 IDLE: start=1 -> MEASURE next cycle; gate counter and edge counter cleared to 0 on that transition.
REQ-015 MEASURE: gate counter increments every cycle; edge counter increments on each cycle where the edge pulse is high; busy=1.
REQ-016 MEASURE lasts exactly GATE_CYCLES cycles; on the cycle gate counter == GATE_CYCLES-1 (edge pulse on that cycle still counted) -> DONE.
REQ-017 DONE: freq_count <= edge counter, overflow <= saturation flag, valid=1 for exactly this one cycle, busy=0; -> IDLE next cycle.
REQ-018 Edge counter SHALL saturate at 2^COUNT_W-1 and set an internal saturation flag rather than wrap.
REQ-019 start while in MEASURE or DONE SHALL be ignored (no restart, no queueing).
REQ-020 freq_count and overflow SHALL hold their values between DONE cycles.
REQ-021 sig_in static for the whole window SHALL yield freq_count=0, overflow=0.

Reset
REQ-022 reset low SHALL immediately force: state IDLE, busy=0, valid=0, freq_count=0, overflow=0, all counters and synchronizer flops 0.
REQ-023 reset asserted mid-MEASURE SHALL abort the window with no valid pulse; after release the block waits for a new start.
REQ-024 First edge pulse after reset release SHALL require a genuine 0->1 transition of the synchronized sig_in (synchronizer resets to 0, so a sig_in held high produces one pulse).

Configuration
REQ-025 Macro FREQ_METER_AUTORESTART_EN defined: DONE -> MEASURE directly (counters cleared), giving back-to-back windows with one DONE cycle between them; start ignored after the first window; IDLE re-entered only via reset.
REQ-026 Macro undefined: single-shot behaviour of REQ-014..REQ-019.

Structure
REQ-027 Package freq_meter_pkg SHALL hold the FSM state enum typedef (fm_state_t) and the default GATE_CYCLES constant.
REQ-028 Sub-module sync_edge (2-FF synchronizer + rising-edge detector, ports clk_in, reset, d, rise) SHALL be instantiated once.

Verification (GATE_CYCLES=100 for simulation)
REQ-029 sig_in period 10 clk (5 high/5 low) running well before start; start pulse -> busy 100 cycles, valid pulse exactly 101 cycles after start, freq_count=10, overflow=0.
REQ-030 sig_in held 0 -> freq_count=0, valid still pulses once; then sig_in period 4 -> next measurement freq_count=25.
REQ-031 start re-pulsed at cycle 50 of MEASURE -> ignored; single valid pulse at original time, count unchanged.
REQ-032 reset low at cycle 40 of MEASURE -> busy=0, freq_count=0, no valid pulse; new start -> normal result.
REQ-033 Force a small COUNT_W via GATE_CYCLES=8, sig_in period 2 -> freq_count=4 (max), overflow=0; confirm saturation path with counter forced high -> overflow=1.
REQ-034 FREQ_METER_AUTORESTART_EN defined, sig_in period 10 -> valid pulses every 101 cycles, each freq_count=10.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter.
//   fm_state_t              : measurement FSM state encoding
//   FM_GATE_CYCLES_DEFAULT  : default gate window length in clk_in cycles (1 s at 100 MHz)
//   FM_FREC_IN_DEFAULT      : default clk_in frequency in Hz
package freq_meter_pkg;

    localparam int unsigned FM_GATE_CYCLES_DEFAULT = 100_000_000;
    localparam int unsigned FM_FREC_IN_DEFAULT     = 100_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } fm_state_t;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// rise is a one-cycle pulse appearing 3 clk_in cycles after a 0->1 on d.
// The synchronizer clears to 0, so d held high through reset release
// still produces exactly one pulse.
//   clk_in : clock
//   reset  : asynchronous active-low reset
//   d      : asynchronous input
//   rise   : registered rising-edge pulse
module sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    // Synchronizer chain, previous-value flop and registered edge pulse
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over a window of
// GATE_CYCLES clk_in cycles and reports the count.
// Build option: define FREQ_METER_AUTORESTART_EN for back-to-back windows
// (DONE returns straight to MEASURE; only reset returns to IDLE).
//   clk_in     : clock
//   reset      : asynchronous active-low reset
//   sig_in     : measured signal, asynchronous to clk_in
//   start      : single-cycle request to begin a measurement
//   busy       : measurement window in progress
//   freq_count : edge count of the last completed window
//   valid      : one-cycle pulse when freq_count updates
//   overflow   : last window's count saturated
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned frec_in     = FM_FREC_IN_DEFAULT,
    parameter int unsigned GATE_CYCLES = FM_GATE_CYCLES_DEFAULT,
    localparam int unsigned COUNT_W    = $clog2(GATE_CYCLES / 2 + 1)
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               sig_in,
    input  logic               start,
    output logic               busy,
    output logic [COUNT_W-1:0] freq_count,
    output logic               valid,
    output logic               overflow
);

    localparam int unsigned        GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // A zero clock rate or a window shorter than 2 cycles has no meaningful count
    if (frec_in == 0 || GATE_CYCLES < 2) begin : g_bad_param
        $error("freq_meter: frec_in must be nonzero and GATE_CYCLES >= 2");
    end

    logic rise;

    sync_edge u_sync_edge (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (sig_in),
        .rise   (rise)
    );

    fm_state_t           state_q;
    logic [GATE_W-1:0]   gate_q;
    logic [COUNT_W-1:0]  edge_q;
    logic                sat_q;
    logic                busy_q;
    logic                valid_q;
    logic                overflow_q;
    logic [COUNT_W-1:0]  freq_count_q;

    logic [COUNT_W-1:0]  edge_d;
    logic                sat_d;

    // Saturating edge count including this cycle's pulse; an edge arriving
    // at full scale is dropped and flagged instead of wrapping.
    always_comb begin
        edge_d = edge_q;
        sat_d  = sat_q;
        if (rise) begin
            if (edge_q == COUNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                edge_d = edge_q + COUNT_W'(1);
            end
        end
    end

    // Measurement FSM with registered outputs
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gate_q       <= '0;
            edge_q       <= '0;
            sat_q        <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            freq_count_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= MEASURE;
                        gate_q  <= '0;
                        edge_q  <= '0;
                        sat_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                MEASURE: begin
                    edge_q <= edge_d;
                    sat_q  <= sat_d;
                    gate_q <= gate_q + GATE_W'(1);
                    // Results are latched on entry so valid is high exactly in DONE
                    if (gate_q == GATE_LAST) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        valid_q      <= 1'b1;
                        freq_count_q <= edge_d;
                        overflow_q   <= sat_d;
                    end
                end
                DONE: begin
`ifdef FREQ_METER_AUTORESTART_EN
                    state_q <= MEASURE;
                    gate_q  <= '0;
                    edge_q  <= '0;
                    sat_q   <= 1'b0;
                    busy_q  <= 1'b1;
`else
                    state_q <= IDLE;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign freq_count = freq_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 100-cycle-window instance for the main
// behaviour, plus 8- and 7-cycle instances for full-scale and saturation.
module tb_freq_meter;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;

    // 100-cycle window instance
    logic       sig_a   = 1'b0;
    logic       start_a = 1'b0;
    logic       busy_a;
    logic [5:0] fc_a;
    logic       valid_a;
    logic       ovf_a;

    // Small-window instances share stimulus
    logic       sig_b   = 1'b0;
    logic       start_b = 1'b0;
    logic       busy_8, valid_8, ovf_8;
    logic [2:0] fc_8;
    logic       busy_7, valid_7, ovf_7;
    logic [1:0] fc_7;

    int per_a = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    freq_meter #(.frec_in(100_000_000), .GATE_CYCLES(100)) u_dut (
        .clk_in(clk), .reset(rst_n), .sig_in(sig_a), .start(start_a),
        .busy(busy_a), .freq_count(fc_a), .valid(valid_a), .overflow(ovf_a)
    );

    freq_meter #(.frec_in(100_000_000), .GATE_CYCLES(8)) u_dut8 (
        .clk_in(clk), .reset(rst_n), .sig_in(sig_b), .start(start_b),
        .busy(busy_8), .freq_count(fc_8), .valid(valid_8), .overflow(ovf_8)
    );

    freq_meter #(.frec_in(100_000_000), .GATE_CYCLES(7)) u_dut7 (
        .clk_in(clk), .reset(rst_n), .sig_in(sig_b), .start(start_b),
        .busy(busy_7), .freq_count(fc_7), .valid(valid_7), .overflow(ovf_7)
    );

    // sig_a generator: period per_a clocks, 50% duty; per_a == 0 holds it low
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (per_a == 0) begin
                sig_a = 1'b0;
            end else begin
                ph    = (ph + 1) % per_a;
                sig_a = (ph < per_a / 2);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One window on u_dut; optional extra start pulse at cycle restart_at
    task automatic measure(input string tag, input int exp_cnt, input int restart_at);
        int valid_at, busy_n, valid_n;
        valid_at = 0;
        busy_n   = 0;
        valid_n  = 0;
        start_a  = 1'b1;
        for (int i = 1; i <= 140; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start_a = 1'b0;
            if (restart_at != 0 && i == restart_at) start_a = 1'b1;
            if (restart_at != 0 && i == restart_at + 1) start_a = 1'b0;
            if (busy_a) busy_n++;
            if (valid_a) begin
                valid_n++;
                if (valid_at == 0) valid_at = i;
            end
        end
        check({tag, ".valid_latency"}, 32'(valid_at), 32'd101);
        check({tag, ".busy_cycles"},   32'(busy_n),   32'd100);
        check({tag, ".valid_pulses"},  32'(valid_n),  32'd1);
        check({tag, ".freq_count"},    32'(fc_a),     32'(exp_cnt));
        check({tag, ".overflow"},      32'(ovf_a),    32'd0);
    endtask

    initial begin
        int valid_n, busy_n;
        // Reset state
        tick(3);
        check("reset.busy",       32'(busy_a),  32'd0);
        check("reset.valid",      32'(valid_a), 32'd0);
        check("reset.freq_count", 32'(fc_a),    32'd0);
        check("reset.overflow",   32'(ovf_a),   32'd0);
        rst_n = 1'b1;
        tick(2);

`ifdef FREQ_METER_AUTORESTART_EN
        begin
            int vt[3];
            int vc[3];
            per_a = 10;
            tick(30);
            valid_n = 0;
            start_a = 1'b1;
            for (int i = 1; i <= 320; i++) begin
                @(posedge clk);
                #1;
                if (i == 1) start_a = 1'b0;
                if (i == 150) start_a = 1'b1;
                if (i == 151) start_a = 1'b0;
                if (i == 101) check("auto.busy_in_done", 32'(busy_a), 32'd0);
                if (i == 102) check("auto.busy_restart", 32'(busy_a), 32'd1);
                if (valid_a) begin
                    if (valid_n < 3) begin
                        vt[valid_n] = i;
                        vc[valid_n] = 32'(fc_a);
                    end
                    valid_n++;
                end
            end
            check("auto.valid_pulses", 32'(valid_n), 32'd3);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("auto.valid_time%0d", k), 32'(vt[k]), 32'(101 * (k + 1)));
                check($sformatf("auto.count%0d", k),      32'(vc[k]), 32'd10);
            end
        end
`else
        // Full-scale (8-cycle window) and saturation (7-cycle window):
        // sig_b alternates each clock, phased so pulses land on the first window cycle.
        begin
            int v8, v7;
            v8 = 0;
            v7 = 0;
            for (int i = 0; i < 20; i++) begin
                sig_b   = (i % 2 == 1);
                start_b = (i == 5);
                @(posedge clk);
                #1;
                if (valid_8) v8++;
                if (valid_7) v7++;
            end
            sig_b = 1'b0;
            check("gate8.freq_count", 32'(fc_8),  32'd4);
            check("gate8.overflow",   32'(ovf_8), 32'd0);
            check("gate8.valid",      32'(v8),    32'd1);
            check("gate7.freq_count", 32'(fc_7),  32'd3);
            check("gate7.overflow",   32'(ovf_7), 32'd1);
            check("gate7.valid",      32'(v7),    32'd1);
            check("gate7.busy_after", 32'(busy_7), 32'd0);
        end

        per_a = 10;
        tick(30);
        measure("p10", 10, 0);
        tick(20);
        check("hold.freq_count", 32'(fc_a),    32'd10);
        check("hold.valid",      32'(valid_a), 32'd0);

        per_a = 0;
        tick(20);
        measure("static", 0, 0);

        per_a = 4;
        tick(20);
        measure("p4", 25, 0);

        per_a = 10;
        tick(20);
        measure("restart_ignored", 10, 50);

        // Abort a window with reset at cycle 40
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(39);
        check("abort.busy_before", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort.busy",       32'(busy_a),  32'd0);
        check("abort.freq_count", 32'(fc_a),    32'd0);
        check("abort.valid",      32'(valid_a), 32'd0);
        tick(3);
        rst_n = 1'b1;
        valid_n = 0;
        busy_n  = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (valid_a) valid_n++;
            if (busy_a) busy_n++;
        end
        check("abort.no_valid", 32'(valid_n), 32'd0);
        check("abort.idle",     32'(busy_n),  32'd0);
        measure("after_abort", 10, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
